// File: rtl/wallace_mul_sched.sv
// Round-robin scheduler sharing one multicycle 16x16 Wallace-tree multiplier among NREQ issue
// ports; operands are held for LAT cycles and the product returns over a valid/ready channel.
module wallace_mul_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4,
  parameter int unsigned LAT  = 2,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic [TAGW-1:0]      res_tag,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     mul_a_q, mul_b_q;
  logic [31:0]     res_data_q;
  logic [IDW-1:0]  res_id_q;
  logic [TAGW-1:0] res_tag_q;
  logic            res_valid_q;

  logic            found;
  logic [IDW-1:0]  gnt;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  idx;
  logic            arb;
  logic            accept;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign arb       = (state_q == StIdle) || ((state_q == StDone) && res_ready);
  // Gating with rst_n keeps every ready bit low while reset is held.
  assign accept    = arb && found && rst_n;
  assign req_ready = accept ? (NREQ'(1) << gnt) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCalc;
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (res_ready) state_d = accept ? StCalc : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      cnt_d = CNTW'(LAT - 1);
      ptr_d = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_tag_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        mul_a_q   <= req_a[16*gnt +: 16];
        mul_b_q   <= req_b[16*gnt +: 16];
        res_tag_q <= req_tag[TAGW*gnt +: TAGW];
        res_id_q  <= gnt;
      end
      if ((state_q == StCalc) && (cnt_q == '0)) begin
        res_data_q  <= mul_y;
        res_valid_q <= 1'b1;
      end else if ((state_q == StDone) && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_tag   = res_tag_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_wallace_mul_sched.sv
// Bench for wallace_mul_sched: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations; a second LAT=1 instance covers the short-latency build.
module tb_wallace_mul_sched;
  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [15:0]          ra [NREQ];
  logic [15:0]          rb [NREQ];
  logic [TAGW-1:0]      rt [NREQ];
  logic [NREQ*16-1:0]   req_a, req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [15:0]          mul_a, mul_b;
  logic [31:0]          mul_y;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [31:0]          res_data;
  logic [1:0]           res_id;
  logic [TAGW-1:0]      res_tag;
  logic                 busy;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[16*g +: 16]     = ra[g];
    assign req_b[16*g +: 16]     = rb[g];
    assign req_tag[TAGW*g +: TAGW] = rt[g];
  end
  assign mul_y = 32'(mul_a) * 32'(mul_b);

  wallace_mul_sched #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_tag(res_tag), .busy(busy)
  );

  // LAT=1 instance
  logic [3:0]  v1 = '0;
  logic [3:0]  ready1;
  logic [63:0] a1 = '0, b1 = '0;
  logic [15:0] tag1 = '0;
  logic [15:0] mul_a1, mul_b1;
  logic [31:0] mul_y1, rd1;
  logic        rv1, busy1;
  logic [1:0]  rid1;
  logic [3:0]  rtag1;
  assign mul_y1 = 32'(mul_a1) * 32'(mul_b1);

  wallace_mul_sched #(.NREQ(4), .TAGW(4), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1), .req_a(a1), .req_b(b1),
    .req_tag(tag1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_y(mul_y1), .res_valid(rv1),
    .res_ready(1'b1), .res_data(rd1), .res_id(rid1), .res_tag(rtag1), .busy(busy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: one outstanding op at most, aged in clock edges since its accept.
  bit          m_pend;
  int          m_age, m_id, m_ptr, m_g;
  logic [31:0] m_data;
  logic [3:0]  m_tag, m_exp_ready;
  logic [15:0] m_ma, m_mb;
  bit          m_hs, m_arb;
  int          glog[$];
  logic [31:0] dlog[$];
  int          idlog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_res_data", res_data, 0);
      m_pend = 0; m_age = 0; m_ptr = 0; m_ma = '0; m_mb = '0;
    end else begin
      m_hs  = m_pend && (m_age >= LAT) && res_ready;
      m_arb = !m_pend || m_hs;
      m_g   = -1;
      for (int off = 0; off < NREQ; off++) begin
        if (m_g < 0 && req_valid[(m_ptr + off) % NREQ]) m_g = (m_ptr + off) % NREQ;
      end
      m_exp_ready = (m_arb && m_g >= 0) ? 4'(1 << m_g) : 4'b0;
      chk("req_ready", req_ready, m_exp_ready);
      chk("busy", busy, m_pend);
      chk("res_valid", res_valid, m_pend && (m_age >= LAT));
      if (m_pend && m_age >= LAT) begin
        chk("res_data", res_data, m_data);
        chk("res_id", res_id, m_id);
        chk("res_tag", res_tag, m_tag);
      end
      chk("mul_a", mul_a, m_ma);
      chk("mul_b", mul_b, m_mb);
      if (m_hs) begin
        dlog.push_back(res_data);
        idlog.push_back(int'(res_id));
      end
      if (m_pend && m_age < LAT) m_age++;
      if (m_hs) m_pend = 0;
      if (m_arb && m_g >= 0) begin
        m_pend = 1; m_age = 0;
        m_data = 32'(ra[m_g]) * 32'(rb[m_g]);
        m_id = m_g; m_tag = rt[m_g]; m_ma = ra[m_g]; m_mb = rb[m_g];
        m_ptr = (m_g + 1) % NREQ;
        glog.push_back(m_g);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t);
    bit got;
    ra[i] = a; rb[i] = b; rt[i] = t;
    req_valid[i] = 1'b1;
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) timeout("issue_accept");
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && busy; n++) tick();
    if (busy) timeout("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0; rb[i] = '0; rt[i] = '0;
    end
    do_reset();

    // Basic latency
    issue(0, 16'd3, 16'd5, 4'hA);
    chk("t1_busy_after_accept", busy, 1);
    chk("t1_valid_k0", res_valid, 0);
    tick();
    chk("t1_valid_k1", res_valid, 0);
    tick();
    chk("t1_valid_k2", res_valid, 1);
    chk("t1_data", res_data, 32'd15);
    chk("t1_id", res_id, 0);
    chk("t1_tag", res_tag, 4'hA);
    drain();

    // Round-robin fairness from pointer 0
    do_reset();
    glog.delete(); dlog.delete(); idlog.delete();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 16'(i + 1); rb[i] = 16'd2; rt[i] = 4'(i);
    end
    req_valid = 4'hF;
    for (int n = 0; n < 60 && glog.size() < 5; n++) tick();
    if (glog.size() < 5) timeout("rr_grants");
    req_valid = 4'h0;
    drain();
    chk("rr_ngrant", glog.size(), 5);
    chk("rr_ndata", dlog.size(), 5);
    if (glog.size() >= 5 && dlog.size() >= 4) begin
      chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 2); chk("rr_g3", glog[3], 3); chk("rr_g4", glog[4], 0);
      chk("rr_d0", dlog[0], 2); chk("rr_d1", dlog[1], 4);
      chk("rr_d2", dlog[2], 6); chk("rr_d3", dlog[3], 8);
    end

    // Backpressure with a pending request on port 1
    dlog.delete(); idlog.delete();
    res_ready = 1'b0;
    issue(0, 16'h0011, 16'h0003, 4'h5);
    for (int n = 0; n < 20 && !res_valid; n++) tick();
    if (!res_valid) timeout("bp_valid");
    ra[1] = 16'd6; rb[1] = 16'd7; rt[1] = 4'h9;
    req_valid = 4'b0010;
    repeat (5) begin
      tick();
      chk("bp_ready", req_ready, 0);
      chk("bp_data", res_data, 32'h33);
      chk("bp_id", res_id, 0);
      chk("bp_tag", res_tag, 4'h5);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0;
    chk("bp_no_bubble_busy", busy, 1);
    chk("bp_valid_drop", res_valid, 0);
    chk("bp_next_id", res_id, 1);
    drain();
    chk("bp_ndata", dlog.size(), 2);
    if (dlog.size() >= 2) begin
      chk("bp_d0", dlog[0], 32'h33);
      chk("bp_d1", dlog[1], 32'd42);
      chk("bp_id1", idlog[1], 1);
    end

    // Corner operands
    dlog.delete();
    issue(2, 16'hFFFF, 16'hFFFF, 4'h1); drain();
    issue(3, 16'h0000, 16'h1234, 4'h2); drain();
    issue(0, 16'h8000, 16'h0002, 4'h3); drain();
    chk("corner_n", dlog.size(), 3);
    if (dlog.size() >= 3) begin
      chk("corner_ffff", dlog[0], 32'hFFFE0001);
      chk("corner_zero", dlog[1], 32'h0);
      chk("corner_8000", dlog[2], 32'h00010000);
    end

    // Reset during CALC aborts the op
    issue(1, 16'h0100, 16'h0100, 4'h7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    ra[3] = 16'h0021; rb[3] = 16'h0003; rt[3] = 4'hE;
    req_valid = 4'b1000;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    glog.delete(); dlog.delete();
    issue(3, 16'h0021, 16'h0003, 4'hE);
    drain();
    chk("post_rst_ngrant", glog.size(), 1);
    chk("post_rst_ndata", dlog.size(), 1);
    if (glog.size() >= 1 && dlog.size() >= 1) begin
      chk("post_rst_grant", glog[0], 3);
      chk("post_rst_data", dlog[0], 32'h63);
    end

    // Pointer returns to 0: after granting port 0 (ptr=1), reset, then 0 wins over 1
    issue(0, 16'd1, 16'd1, 4'h0); drain();
    do_reset();
    ra[0] = 16'd2; rb[0] = 16'd2; ra[1] = 16'd3; rb[1] = 16'd3;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("ptr_reset_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0;
    drain();

    // LAT=1 instance
    a1[15:0] = 16'd7; b1[15:0] = 16'd9; tag1[3:0] = 4'h4;
    v1 = 4'b0001;
    begin
      bit got1;
      got1 = 0;
      for (int n = 0; n < 20 && !got1; n++) begin
        @(negedge clk);
        if (ready1[0]) got1 = 1;
      end
      if (!got1) timeout("lat1_accept");
    end
    tick();
    v1 = 4'b0;
    chk("lat1_valid_k0", rv1, 0);
    tick();
    chk("lat1_valid_k1", rv1, 1);
    chk("lat1_data", rd1, 32'd63);
    chk("lat1_id", rid1, 0);
    chk("lat1_tag", rtag1, 4'h4);
    repeat (2) tick();
    chk("lat1_idle", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wallace_mul_sched.md
Name: wallace_mul_sched

Overview:
- Shares one 16x16 unsigned Wallace-tree multiplier among NREQ requesting functional-unit issue ports of the scoreboard core.
- Arbitrates round-robin and registers the chosen operands onto the multiplier inputs.
- Holds the operands stable for LAT cycles, because the tree is treated as a multicycle combinational path.
- Captures the 32-bit product and returns it with the requester's id and tag over a valid/ready result channel.

Parameters:
NREQ, 4, number of requesters (2..8)
TAGW, 4, width of the opaque destination tag carried with each op
LAT, 2, cycles the multiplier inputs are held before the product is sampled (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester op valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_a  input  NREQ*16  multiplicand, requester i at bits [16i+15:16i]
req_b  input  NREQ*16  multiplier, same packing
req_tag  input  NREQ*TAGW  destination tag, same packing
mul_a  output  16  registered operand to Wallace tree
mul_b  output  16  registered operand to Wallace tree
mul_y  input  32  product from Wallace tree
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  32  registered product
res_id  output  clog2(NREQ)  index of requester served
res_tag  output  TAGW  tag of served op
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr pointer=0, cnt=0.
  - mul_a, mul_b, res_data, res_id, res_tag, res_valid, busy all 0.
  - Reset mid-operation aborts the op: no result is produced and req_ready is 0 while reset is held.
- States:
  - IDLE: arbiter enabled.
  - CALC: counting.
  - DONE: result presented.
- Arbiter enable (ARB): true in IDLE, or in DONE while res_ready=1.
- Grant g: first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ.
- When ARB is true and any request is valid:
  - req_ready[g]=1 combinationally; all other ready bits are 0.
  - On the edge: latch mul_a, mul_b, res_tag, res_id from requester g; cnt<=LAT-1; ptr<=(g+1) mod NREQ; state<=CALC.
- ARB with no valid request:
  - From IDLE: stay IDLE.
  - From DONE: go to IDLE.
- req_ready is 0 in CALC, and in DONE while res_ready=0.
- CALC:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: res_data<=mul_y, res_valid<=1, state<=DONE.
- Latency: accept at edge k gives res_valid high from edge k+LAT.
- mul_a/mul_b change only on an accept edge; they are stable through CALC and DONE.
- DONE:
  - res_valid, res_data, res_id, res_tag are held unchanged until res_valid&res_ready.
  - On the handshake edge, res_valid<=0, unless a new accept occurs on that same edge. In that case the result channel drops and the next op goes to CALC with no IDLE bubble.
- Product: unsigned full 32 bits, no truncation or sign handling.
- Requesters must hold a/b/tag stable while valid and not ready; the block does not buffer unaccepted requests.
- Peak throughput: one op per LAT+1 cycles when res_ready stays high.
- busy is combinational from state.

Test Plan:
- Reset/basic latency (LAT=2):
  - Stimulus: req_valid=0001, a=3, b=5, tag=0xA.
  - Required: req_ready=0001 for one cycle; res_valid rises 2 edges after accept; res_data=15, res_id=0, res_tag=0xA; busy high from accept to handshake.
- Round-robin fairness:
  - Stimulus: req_valid=1111 held continuously, res_ready=1.
  - Required: grants in order 0,1,2,3,0; with a=i+1 and b=2, results 2,4,6,8 are returned in that order.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid rises, with req_valid=0010 pending.
  - Required: res_data/res_id/res_tag unchanged; req_ready=0000; requester 1 is accepted on the edge res_ready rises, and CALC follows with no IDLE cycle.
- Corner operands:
  - 0xFFFF*0xFFFF -> 0xFFFE0001.
  - 0x0000*0x1234 -> 0.
  - 0x8000*0x0002 -> 0x00010000.
- Reset mid-op:
  - Stimulus: rst_n low during CALC.
  - Required: immediately res_valid=0, busy=0, mul_a=mul_b=0; after release, req_valid=1000 is granted to requester 3 (pointer back to 0).
- LAT=1 build:
  - Stimulus: single op 7*9.
  - Required: res_valid 1 edge after accept, res_data=63.
